// File: rtl/index_to_one_hot_wake_queue.sv
// Wake queue: binary-indexed wake events are decoded into a pending bitmap and
// issued one at a time as a registered one-hot grant with round-robin fairness.
module index_to_one_hot_wake_queue #(
  parameter int NUM_SIGNALS = 4,
  parameter int INDEX_WIDTH = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   post_valid,
  input  logic [INDEX_WIDTH-1:0] post_index,
  input  logic                   cancel_valid,
  input  logic [INDEX_WIDTH-1:0] cancel_index,
  input  logic                   grant_ready,
  output logic                   grant_valid,
  output logic [NUM_SIGNALS-1:0] grant_one_hot,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic [NUM_SIGNALS-1:0] pending,
  output logic                   dup_post,
  output logic                   bad_index
);

  function automatic logic [NUM_SIGNALS-1:0] decode(input logic [INDEX_WIDTH-1:0] idx);
    logic [NUM_SIGNALS-1:0] v;
    for (int i = 0; i < NUM_SIGNALS; i++) v[i] = (idx == INDEX_WIDTH'(i));
    return v;
  endfunction

  logic [INDEX_WIDTH-1:0] grant_idx;
  logic [INDEX_WIDTH-1:0] rr_ptr;

  logic                   post_ok;
  logic                   cancel_ok;
  logic                   cancel_grant;
  logic                   load;
  logic                   post_held;
  logic [NUM_SIGNALS-1:0] p;
  logic                   sel_found;
  logic [INDEX_WIDTH-1:0] sel_idx;
  int                     cand;

  logic                   grant_valid_next;
  logic [INDEX_WIDTH-1:0] grant_idx_next;
  logic [INDEX_WIDTH-1:0] rr_ptr_next;
  logic [NUM_SIGNALS-1:0] pending_next;
  logic                   dup_next;
  logic                   bad_next;

  always_comb begin
    post_ok      = post_valid && (32'(post_index) < NUM_SIGNALS);
    cancel_ok    = cancel_valid && (32'(cancel_index) < NUM_SIGNALS);
    cancel_grant = grant_valid && cancel_ok && (cancel_index == grant_idx);
    load         = !grant_valid || grant_ready || cancel_grant;
    // A post to a grant that stays in the register merges with it.
    post_held    = grant_valid && !load && (post_index == grant_idx);

    p = pending;
    if (cancel_ok) p = p & ~decode(cancel_index);
    if (post_ok && !post_held) p = p | decode(post_index);

    dup_next = post_ok && (post_held ||
               (((pending & decode(post_index)) != '0) &&
                !(cancel_ok && (cancel_index == post_index))));
    bad_next = (post_valid && !post_ok) || (cancel_valid && !cancel_ok);

    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_SIGNALS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_SIGNALS) cand = cand - NUM_SIGNALS;
      if (!sel_found && p[cand]) begin
        sel_found = 1'b1;
        sel_idx   = INDEX_WIDTH'(cand);
      end
    end

    grant_valid_next = grant_valid;
    grant_idx_next   = grant_idx;
    rr_ptr_next      = rr_ptr;
    pending_next     = p;
    if (load) begin
      if (sel_found) begin
        grant_valid_next = 1'b1;
        grant_idx_next   = sel_idx;
        rr_ptr_next      = sel_idx;
        pending_next     = p & ~decode(sel_idx);
      end else begin
        grant_valid_next = 1'b0;
        grant_idx_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= INDEX_WIDTH'(NUM_SIGNALS - 1);
      pending     <= '0;
      dup_post    <= 1'b0;
      bad_index   <= 1'b0;
    end else begin
      grant_valid <= grant_valid_next;
      grant_idx   <= grant_idx_next;
      rr_ptr      <= rr_ptr_next;
      pending     <= pending_next;
      dup_post    <= dup_next;
      bad_index   <= bad_next;
    end
  end

  assign grant_one_hot = grant_valid ? decode(grant_idx) : '0;
  assign grant_index   = grant_idx;

endmodule

// File: tb/tb_index_to_one_hot_wake_queue.sv
// Directed bench for the wake queue: a 4-lane instance and a 5-lane instance
// (for out-of-range indices and modulo wrap).
module tb_index_to_one_hot_wake_queue;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       a_post_valid, a_cancel_valid, a_grant_ready;
  logic [1:0] a_post_index, a_cancel_index;
  logic       a_grant_valid, a_dup_post, a_bad_index;
  logic [3:0] a_grant_one_hot, a_pending;
  logic [1:0] a_grant_index;

  logic       b_post_valid, b_cancel_valid, b_grant_ready;
  logic [2:0] b_post_index, b_cancel_index;
  logic       b_grant_valid, b_dup_post, b_bad_index;
  logic [4:0] b_grant_one_hot, b_pending;
  logic [2:0] b_grant_index;

  int checks = 0;
  int failures = 0;

  index_to_one_hot_wake_queue #(.NUM_SIGNALS(4)) u4 (
    .clk(clk), .reset_n(reset_n),
    .post_valid(a_post_valid), .post_index(a_post_index),
    .cancel_valid(a_cancel_valid), .cancel_index(a_cancel_index),
    .grant_ready(a_grant_ready), .grant_valid(a_grant_valid),
    .grant_one_hot(a_grant_one_hot), .grant_index(a_grant_index),
    .pending(a_pending), .dup_post(a_dup_post), .bad_index(a_bad_index)
  );

  index_to_one_hot_wake_queue #(.NUM_SIGNALS(5)) u5 (
    .clk(clk), .reset_n(reset_n),
    .post_valid(b_post_valid), .post_index(b_post_index),
    .cancel_valid(b_cancel_valid), .cancel_index(b_cancel_index),
    .grant_ready(b_grant_ready), .grant_valid(b_grant_valid),
    .grant_one_hot(b_grant_one_hot), .grant_index(b_grant_index),
    .pending(b_pending), .dup_post(b_dup_post), .bad_index(b_bad_index)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic gv, input logic [3:0] oh,
                       input logic [1:0] gi, input logic [3:0] pd);
    chk({tag, ".gv"}, 32'(a_grant_valid), 32'(gv));
    chk({tag, ".oh"}, 32'(a_grant_one_hot), 32'(oh));
    chk({tag, ".gi"}, 32'(a_grant_index), 32'(gi));
    chk({tag, ".pend"}, 32'(a_pending), 32'(pd));
  endtask

  initial begin
    a_post_valid = 1'b1; a_post_index = 2'd1; a_cancel_valid = 1'b0; a_cancel_index = 2'd0;
    a_grant_ready = 1'b1;
    b_post_valid = 1'b1; b_post_index = 3'd2; b_cancel_valid = 1'b0; b_cancel_index = 3'd0;
    b_grant_ready = 1'b1;
    reset_n = 1'b0;
    step(); step();
    chk_a("rst", 1'b0, 4'b0000, 2'd0, 4'b0000);
    chk("rst.dup", 32'(a_dup_post), 32'd0);
    chk("rst.bad", 32'(a_bad_index), 32'd0);
    chk("rst5.gv", 32'(b_grant_valid), 32'd0);
    chk("rst5.pend", 32'(b_pending), 32'd0);

    a_post_valid = 1'b0; b_post_valid = 1'b0;
    reset_n = 1'b1;
    step();
    chk_a("idle", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // First post after reset: lane 0 has priority, one-cycle latency.
    a_post_valid = 1'b1; a_post_index = 2'd0;
    step();
    chk_a("first", 1'b1, 4'b0001, 2'd0, 4'b0000);
    a_post_valid = 1'b0;
    step();
    chk("first.drain", 32'(a_grant_valid), 32'd0);

    // Single post idx 2.
    a_post_valid = 1'b1; a_post_index = 2'd2;
    step();
    chk_a("single", 1'b1, 4'b0100, 2'd2, 4'b0000);
    a_post_valid = 1'b0;
    step();
    chk_a("single.drain", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // Backpressure: posts 3,1,0, grant 3 held; then order 0,1.
    a_grant_ready = 1'b0;
    a_post_valid = 1'b1; a_post_index = 2'd3;
    step();
    chk_a("bp.3", 1'b1, 4'b1000, 2'd3, 4'b0000);
    a_post_index = 2'd1;
    step();
    chk_a("bp.1", 1'b1, 4'b1000, 2'd3, 4'b0010);
    a_post_index = 2'd0;
    step();
    chk_a("bp.0", 1'b1, 4'b1000, 2'd3, 4'b0011);
    a_post_valid = 1'b0; a_grant_ready = 1'b1;
    step();
    chk_a("rr.g0", 1'b1, 4'b0001, 2'd0, 4'b0010);
    step();
    chk_a("rr.g1", 1'b1, 4'b0010, 2'd1, 4'b0000);
    step();
    chk_a("rr.empty", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // Duplicate post to a pending lane merges.
    a_grant_ready = 1'b0;
    a_post_valid = 1'b1; a_post_index = 2'd3;
    step();
    chk_a("dup.hold3", 1'b1, 4'b1000, 2'd3, 4'b0000);
    a_post_index = 2'd1;
    step();
    chk("dup.first", 32'(a_dup_post), 32'd0);
    chk("dup.pend1", 32'(a_pending), 32'b0010);
    step();
    chk("dup.pulse", 32'(a_dup_post), 32'd1);
    chk("dup.pend2", 32'(a_pending), 32'b0010);
    a_post_valid = 1'b0;
    step();
    chk("dup.clear", 32'(a_dup_post), 32'd0);
    a_grant_ready = 1'b1;
    step();
    chk_a("dup.g1", 1'b1, 4'b0010, 2'd1, 4'b0000);
    step();
    chk_a("dup.once", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // Post to the lane being accepted is a new event, not a duplicate.
    a_grant_ready = 1'b0;
    a_post_valid = 1'b1; a_post_index = 2'd2;
    step();
    chk_a("acc.hold2", 1'b1, 4'b0100, 2'd2, 4'b0000);
    a_grant_ready = 1'b1;
    step();
    chk_a("acc.again", 1'b1, 4'b0100, 2'd2, 4'b0000);
    chk("acc.nodup", 32'(a_dup_post), 32'd0);
    a_post_valid = 1'b0;
    step();
    chk("acc.drain", 32'(a_grant_valid), 32'd0);

    // Cancel of the held grant: reload from pending, idx 2 never delivered.
    a_grant_ready = 1'b0;
    a_post_valid = 1'b1; a_post_index = 2'd2;
    step();
    chk_a("can.hold2", 1'b1, 4'b0100, 2'd2, 4'b0000);
    a_post_index = 2'd3;
    step();
    chk_a("can.pend3", 1'b1, 4'b0100, 2'd2, 4'b1000);
    a_post_valid = 1'b0; a_cancel_valid = 1'b1; a_cancel_index = 2'd2;
    step();
    chk_a("can.reload", 1'b1, 4'b1000, 2'd3, 4'b0000);
    a_cancel_valid = 1'b0; a_grant_ready = 1'b1;
    step();
    chk_a("can.drain", 1'b0, 4'b0000, 2'd0, 4'b0000);

    // 5-lane instance: out-of-range indices and same-cycle post/cancel.
    b_grant_ready = 1'b0;
    b_post_valid = 1'b1; b_post_index = 3'd0;
    step();
    chk("b.hold0", 32'(b_grant_one_hot), 32'b00001);
    b_post_index = 3'd6;
    step();
    chk("b.bad.pend", 32'(b_pending), 32'd0);
    chk("b.bad.pulse", 32'(b_bad_index), 32'd1);
    b_post_valid = 1'b0;
    step();
    chk("b.bad.clear", 32'(b_bad_index), 32'd0);
    b_cancel_valid = 1'b1; b_cancel_index = 3'd7;
    step();
    chk("b.badc.pulse", 32'(b_bad_index), 32'd1);
    chk("b.badc.gi", 32'(b_grant_index), 32'd0);
    b_post_valid = 1'b1; b_post_index = 3'd4; b_cancel_index = 3'd4;
    step();
    chk("b.pc.pend", 32'(b_pending), 32'b10000);
    chk("b.pc.bad", 32'(b_bad_index), 32'd0);
    b_post_valid = 1'b0; b_cancel_valid = 1'b0; b_grant_ready = 1'b1;
    step();
    chk("b.g4.oh", 32'(b_grant_one_hot), 32'b10000);
    chk("b.g4.gi", 32'(b_grant_index), 32'd4);
    b_post_valid = 1'b1; b_post_index = 3'd0;
    step();
    chk("b.wrap.oh", 32'(b_grant_one_hot), 32'b00001);
    b_post_valid = 1'b0;
    step();
    chk("b.drain", 32'(b_grant_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
